// File: rtl/hazard_scoreboard_if.sv
// Pipeline-side bundle for hazard_scoreboard: decode/execute/mem/wb indices,
// long-unit status and perf clear in; stall/flush/forward/scoreboard/counters out.
interface hazard_scoreboard_if #(
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS),
  parameter int CNT_W = 16
);
  logic [AW-1:0]    Rs1D, Rs2D, RdD;
  logic             UsesRs1D, UsesRs2D, LongOpD;
  logic [AW-1:0]    Rs1E, Rs2E, RdE;
  logic             LoadE, LongIssueE, PCSrcE;
  logic             SrcAImmE, ALUSrcE;
  logic [AW-1:0]    RdM, RdW;
  logic             RegWriteM, RegWriteW;
  logic             LongWbValid;
  logic [AW-1:0]    LongWbRd;
  logic             LongUnitBusy;
  logic             PerfClr;
  logic             StallF, StallD, FlushD, FlushE;
  logic [1:0]       ForwardAE, ForwardBE;
  logic [NREGS-1:0] PendingMask;
  logic             ScoreboardBusy;
  logic [CNT_W-1:0] LoadStallCnt, SbStallCnt, FlushCnt;

  modport master (
    output Rs1D, Rs2D, RdD, UsesRs1D, UsesRs2D, LongOpD,
    output Rs1E, Rs2E, RdE, LoadE, LongIssueE, PCSrcE,
    output SrcAImmE, ALUSrcE, RdM, RdW, RegWriteM, RegWriteW,
    output LongWbValid, LongWbRd, LongUnitBusy, PerfClr,
    input  StallF, StallD, FlushD, FlushE,
    input  ForwardAE, ForwardBE, PendingMask, ScoreboardBusy,
    input  LoadStallCnt, SbStallCnt, FlushCnt
  );

  modport slave (
    input  Rs1D, Rs2D, RdD, UsesRs1D, UsesRs2D, LongOpD,
    input  Rs1E, Rs2E, RdE, LoadE, LongIssueE, PCSrcE,
    input  SrcAImmE, ALUSrcE, RdM, RdW, RegWriteM, RegWriteW,
    input  LongWbValid, LongWbRd, LongUnitBusy, PerfClr,
    output StallF, StallD, FlushD, FlushE,
    output ForwardAE, ForwardBE, PendingMask, ScoreboardBusy,
    output LoadStallCnt, SbStallCnt, FlushCnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard unit: M/W forwarding, load-use, long-op pending-write scoreboard,
// busy-unit stall, branch priority. Ports: clk, rst_n, bus (slave).
// Define HAZARD_PERF_EN for saturating stall/flush counters (else tied 0).
module hazard_scoreboard #(
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS),
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  hazard_scoreboard_if.slave bus
);
  logic [NREGS-1:0] pendingMask;
  logic [NREGS-1:0] setVec, clrVec, nextMask;
  logic             issueValid;
  logic             src1v, src2v;
  logic             lwStall, sbStall, structStall, hz;
  logic [1:0]       fwdA, fwdB;

  function automatic logic [1:0] fwdSel(
    input logic          imm,
    input logic [AW-1:0] rs
  );
    logic [1:0] sel;
    if (imm)
      sel = 2'b11;
    else if (rs != '0 && rs == bus.RdM && bus.RegWriteM)
      sel = 2'b10;
    else if (rs != '0 && rs == bus.RdW && bus.RegWriteW)
      sel = 2'b01;
    else
      sel = 2'b00;
    return sel;
  endfunction

  // An op issuing this edge is pending for D already, before its bit lands.
  function automatic logic sbHit(input logic [AW-1:0] r);
    return pendingMask[r] || (issueValid && bus.RdE == r);
  endfunction

  assign fwdA = fwdSel(bus.SrcAImmE, bus.Rs1E);
  assign fwdB = fwdSel(bus.ALUSrcE, bus.Rs2E);

  assign issueValid = bus.LongIssueE && bus.RdE != '0;
  assign src1v = bus.UsesRs1D && bus.Rs1D != '0;
  assign src2v = bus.UsesRs2D && bus.Rs2D != '0;

  assign lwStall = bus.LoadE && bus.RdE != '0 &&
                   ((src1v && bus.Rs1D == bus.RdE) ||
                    (src2v && bus.Rs2D == bus.RdE));

  // RdD term catches WAW against a still-pending long op.
  assign sbStall = (src1v && sbHit(bus.Rs1D)) ||
                   (src2v && sbHit(bus.Rs2D)) ||
                   (bus.RdD != '0 && sbHit(bus.RdD));

  assign structStall = bus.LongOpD &&
                       (bus.LongUnitBusy || bus.LongIssueE);

  assign hz = lwStall || sbStall || structStall;

  assign bus.StallF    = hz && !bus.PCSrcE;
  assign bus.StallD    = hz && !bus.PCSrcE;
  assign bus.FlushD    = bus.PCSrcE;
  assign bus.FlushE    = bus.PCSrcE || hz;
  assign bus.ForwardAE = fwdA;
  assign bus.ForwardBE = fwdB;

  // Set is OR-ed after the clear so a same-index set/clear keeps the bit.
  assign setVec   = issueValid ? (NREGS'(1) << bus.RdE) : '0;
  assign clrVec   = bus.LongWbValid ? (NREGS'(1) << bus.LongWbRd) : '0;
  assign nextMask = ((pendingMask & ~clrVec) | setVec) & ~NREGS'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pendingMask <= '0;
    else
      pendingMask <= nextMask;
  end

  assign bus.PendingMask    = pendingMask;
  assign bus.ScoreboardBusy = |pendingMask;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] loadCnt, sbCnt, flushCnt;

  function automatic logic [CNT_W-1:0] satInc(
    input logic [CNT_W-1:0] c,
    input logic             en
  );
    return (en && c != '1) ? c + CNT_W'(1) : c;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loadCnt  <= '0;
      sbCnt    <= '0;
      flushCnt <= '0;
    end else if (bus.PerfClr) begin
      loadCnt  <= '0;
      sbCnt    <= '0;
      flushCnt <= '0;
    end else begin
      loadCnt  <= satInc(loadCnt, lwStall && !bus.PCSrcE);
      sbCnt    <= satInc(sbCnt, (sbStall || structStall) &&
                         !lwStall && !bus.PCSrcE);
      flushCnt <= satInc(flushCnt, bus.PCSrcE);
    end
  end

  assign bus.LoadStallCnt = loadCnt;
  assign bus.SbStallCnt   = sbCnt;
  assign bus.FlushCnt     = flushCnt;
`else
  logic unusedPerfClr;
  assign unusedPerfClr    = bus.PerfClr;
  assign bus.LoadStallCnt = '0;
  assign bus.SbStallCnt   = '0;
  assign bus.FlushCnt     = '0;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector bench for hazard_scoreboard (CNT_W=4 for saturation).
// Counter expectations collapse to 0 unless HAZARD_PERF_EN is defined.
module tb_hazard_scoreboard;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   vecs;
  int   errs;

  hazard_scoreboard_if #(.NREGS(32), .CNT_W(4)) bus ();

  hazard_scoreboard #(.NREGS(32), .CNT_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pc(input int v);
    return PERF ? 32'(v) : 32'd0;
  endfunction

  task automatic idle();
    bus.Rs1D = '0; bus.Rs2D = '0; bus.RdD = '0;
    bus.UsesRs1D = 0; bus.UsesRs2D = 0; bus.LongOpD = 0;
    bus.Rs1E = '0; bus.Rs2E = '0; bus.RdE = '0;
    bus.LoadE = 0; bus.LongIssueE = 0; bus.PCSrcE = 0;
    bus.SrcAImmE = 0; bus.ALUSrcE = 0;
    bus.RdM = '0; bus.RdW = '0;
    bus.RegWriteM = 0; bus.RegWriteW = 0;
    bus.LongWbValid = 0; bus.LongWbRd = '0;
    bus.LongUnitBusy = 0; bus.PerfClr = 0;
  endtask

  task automatic checkCnt(input string tag, input int l, input int s, input int f);
    check({tag, "_load"}, 32'(bus.LoadStallCnt), pc(l));
    check({tag, "_sb"}, 32'(bus.SbStallCnt), pc(s));
    check({tag, "_flush"}, 32'(bus.FlushCnt), pc(f));
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs = 0;
    errs = 0;
    idle();
    rst_n = 1'b0;
    #1;
    check("rst_mask", bus.PendingMask, 32'h0);
    check("rst_busy", 32'(bus.ScoreboardBusy), 32'd0);
    checkCnt("rst", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // forwarding
    @(negedge clk);
    idle();
    bus.RdM = 5; bus.RegWriteM = 1;
    bus.RdW = 5; bus.RegWriteW = 1;
    bus.Rs1E = 5; bus.Rs2E = 5;
    #1;
    check("fwdA_m", 32'(bus.ForwardAE), 32'd2);
    check("fwdB_m", 32'(bus.ForwardBE), 32'd2);
    bus.Rs2E = 0;
    #1;
    check("fwdB_x0", 32'(bus.ForwardBE), 32'd0);
    bus.Rs2E = 5; bus.ALUSrcE = 1;
    #1;
    check("fwdB_imm", 32'(bus.ForwardBE), 32'd3);
    check("fwdA_keep", 32'(bus.ForwardAE), 32'd2);
    bus.RegWriteM = 0;
    #1;
    check("fwdA_w", 32'(bus.ForwardAE), 32'd1);
    bus.SrcAImmE = 1;
    #1;
    check("fwdA_imm", 32'(bus.ForwardAE), 32'd3);

    // load-use
    @(negedge clk);
    idle();
    bus.LoadE = 1; bus.RdE = 7; bus.Rs2D = 7; bus.UsesRs2D = 1;
    #1;
    check("lw_stallF", 32'(bus.StallF), 32'd1);
    check("lw_stallD", 32'(bus.StallD), 32'd1);
    check("lw_flushE", 32'(bus.FlushE), 32'd1);
    check("lw_flushD", 32'(bus.FlushD), 32'd0);
    @(posedge clk);
    #1;
    checkCnt("lw", 1, 0, 0);
    @(negedge clk);
    bus.RdE = 0;
    #1;
    check("lw_x0", 32'(bus.StallF), 32'd0);
    check("lw_x0_fe", 32'(bus.FlushE), 32'd0);

    // branch over load-use stall
    @(negedge clk);
    idle();
    bus.LoadE = 1; bus.RdE = 7; bus.Rs1D = 7; bus.UsesRs1D = 1;
    bus.PCSrcE = 1;
    #1;
    check("br_stallF", 32'(bus.StallF), 32'd0);
    check("br_stallD", 32'(bus.StallD), 32'd0);
    check("br_flushD", 32'(bus.FlushD), 32'd1);
    check("br_flushE", 32'(bus.FlushE), 32'd1);
    @(posedge clk);
    #1;
    checkCnt("br", 1, 0, 1);

    // scoreboard RAW on x9
    @(negedge clk);
    idle();
    bus.LongIssueE = 1; bus.RdE = 9;
    @(negedge clk);
    idle();
    check("sb_mask9", bus.PendingMask, 32'h200);
    check("sb_busy", 32'(bus.ScoreboardBusy), 32'd1);
    bus.Rs1D = 9; bus.UsesRs1D = 1;
    #1;
    check("sb_stall0", 32'(bus.StallD), 32'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      check("sb_stallN", 32'(bus.StallD), 32'd1);
    end
    @(negedge clk);
    bus.LongWbValid = 1; bus.LongWbRd = 9;
    #1;
    check("sb_stallWb", 32'(bus.StallD), 32'd1);
    @(negedge clk);
    bus.LongWbValid = 0;
    #1;
    check("sb_clr", bus.PendingMask, 32'h0);
    check("sb_drop", 32'(bus.StallD), 32'd0);
    checkCnt("sb", 1, 4, 1);

    // in-flight issue hit and WAW
    @(negedge clk);
    idle();
    bus.LongIssueE = 1; bus.RdE = 3; bus.RdD = 3;
    #1;
    check("waw_issue", 32'(bus.StallD), 32'd1);
    @(negedge clk);
    idle();
    bus.RdD = 3;
    #1;
    check("waw_mask", bus.PendingMask, 32'h8);
    check("waw_stall", 32'(bus.StallD), 32'd1);
    @(negedge clk);
    idle();
    bus.LongIssueE = 1; bus.RdE = 4;
    bus.LongWbValid = 1; bus.LongWbRd = 4;
    #1;
    check("waw_nostall", 32'(bus.StallD), 32'd0);
    @(negedge clk);
    idle();
    check("setwins", bus.PendingMask, 32'h18);
    bus.LongWbValid = 1; bus.LongWbRd = 3;
    @(negedge clk);
    idle();
    check("clr3", bus.PendingMask, 32'h10);
    bus.LongWbValid = 1; bus.LongWbRd = 5;
    @(negedge clk);
    idle();
    check("clr_noop", bus.PendingMask, 32'h10);
    bus.LongOpD = 1; bus.LongUnitBusy = 1;
    #1;
    check("struct", 32'(bus.StallD), 32'd1);
    @(negedge clk);
    idle();
    bus.LongWbValid = 1; bus.LongWbRd = 4;
    @(negedge clk);
    idle();
    check("clr4", bus.PendingMask, 32'h0);
    checkCnt("waw", 1, 7, 1);

    // async reset mid-operation
    bus.LongIssueE = 1; bus.RdE = 9;
    @(negedge clk);
    bus.RdE = 10;
    @(negedge clk);
    idle();
    check("pre_rst", bus.PendingMask, 32'h600);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst", bus.PendingMask, 32'h0);
    checkCnt("mid_rst", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // flush saturation and clear priority
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      idle();
      bus.PCSrcE = 1;
    end
    @(negedge clk);
    idle();
    checkCnt("sat", 0, 0, 15);
    bus.PCSrcE = 1; bus.PerfClr = 1;
    @(negedge clk);
    idle();
    checkCnt("clr", 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the 5-stage pipeline hazard unit.
- Keeps M/W forwarding and load-use detection.
- Adds a per-register pending-write scoreboard for variable-latency long ops (mul/div), a structural stall for a busy long unit, branch-over-stall priority, and optional saturating performance counters.
- Sits beside the datapath; drives stall, flush and forward-mux selects.

Parameters:
NREGS, 32, architectural register count (power of two, ≥2)
AW, $clog2(NREGS), register-index width
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
Rs1D, Rs2D, RdD  in  AW  decode-stage register indices
UsesRs1D, UsesRs2D  in  1  D instruction reads rs1/rs2
LongOpD  in  1  D instruction is a long op
Rs1E, Rs2E, RdE  in  AW  execute-stage indices
LoadE  in  1  E instruction is a load
LongIssueE  in  1  E instruction issues to the long unit at this edge
PCSrcE  in  1  taken branch/jump in E
SrcAImmE, ALUSrcE  in  1  A-operand is PC/imm; B-operand is imm
RdM, RdW  in  AW  destination indices, M and W stages
RegWriteM, RegWriteW  in  1  register write enables, M and W stages
LongWbValid  in  1  long unit writes back this cycle
LongWbRd  in  AW  long-unit destination
LongUnitBusy  in  1  long unit cannot accept an op
PerfClr  in  1  synchronous clear of the counters
StallF, StallD, FlushD, FlushE  out  1  pipeline control
ForwardAE, ForwardBE  out  2  00 RF, 01 W, 10 M, 11 PC/imm
PendingMask  out  NREGS  scoreboard state
ScoreboardBusy  out  1  OR of PendingMask
LoadStallCnt, SbStallCnt, FlushCnt  out  CNT_W  performance counters

Behaviour:
- Reset (rst_n low, asynchronous): PendingMask = 0 and all counters = 0. All other outputs are combinational.
- Forwarding A:
  - SrcAImmE → 11.
  - Else Rs1E≠0, Rs1E==RdM, RegWriteM → 10.
  - Else Rs1E≠0, Rs1E==RdW, RegWriteW → 01.
  - Else 00.
- Forwarding B: same rules with ALUSrcE/Rs2E. Only ForwardBE is written; the two muxes are fully independent.
- Source valid: srcXv = UsesRsXD && RsXD≠0.
- lwStall = LoadE && RdE≠0 && (src1v&&Rs1D==RdE || src2v&&Rs2D==RdE).
- sbHit(r) = PendingMask[r] || (LongIssueE && RdE==r && RdE≠0).
- sbStall = (src1v&&sbHit(Rs1D)) || (src2v&&sbHit(Rs2D)) || (RdD≠0 && sbHit(RdD)). The RdD term is the WAW hazard.
- structStall = LongOpD && (LongUnitBusy || LongIssueE).
- hz = lwStall || sbStall || structStall.
- Control outputs:
  - StallF = StallD = hz && !PCSrcE. A taken branch overrides stalls so the target fetch proceeds.
  - FlushD = PCSrcE.
  - FlushE = PCSrcE || hz.
- Scoreboard update, each posedge:
  - Set PendingMask[RdE] if LongIssueE && RdE≠0.
  - Clear PendingMask[LongWbRd] if LongWbValid.
  - Set and clear of the same index in one cycle → set wins.
  - Bit 0 is never set.
  - A clear of a non-pending index is a no-op.
- ScoreboardBusy = |PendingMask.
- Counters (saturate at all-ones, no wrap; PerfClr zeroes all three and has priority over increments):
  - LoadStallCnt: +1 per cycle with lwStall && !PCSrcE.
  - SbStallCnt: +1 per cycle with (sbStall||structStall) && !lwStall && !PCSrcE.
  - FlushCnt: +1 per cycle with PCSrcE.
- Reset mid-operation: in-flight pending bits are discarded. The long unit must also be reset.

Optional Feature:
- HAZARD_PERF_EN defined: the three counters and PerfClr are implemented as above.
- HAZARD_PERF_EN undefined: no counter flops; LoadStallCnt, SbStallCnt and FlushCnt are tied 0; PerfClr is ignored. All other behaviour is unchanged.

Test Plan:
- Forwarding: RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5, Rs2E=5 → ForwardAE=ForwardBE=10. With Rs2E=0 → ForwardBE=00. With ALUSrcE=1 → ForwardBE=11 and ForwardAE stays 10.
- Load-use: LoadE=1, RdE=7, Rs2D=7, UsesRs2D=1 → StallF=StallD=FlushE=1, LoadStallCnt +1. With RdE=0 → no stall.
- Scoreboard: LongIssueE=1, RdE=9 at edge → PendingMask[9]=1, ScoreboardBusy=1. D reads x9 → stall every cycle until LongWbValid, LongWbRd=9; the bit clears at that edge and the stall drops the next cycle.
- WAW and same-cycle set/clear: PendingMask[3]=1, RdD=3 → stall. LongIssueE RdE=4 with LongWbValid LongWbRd=4 in the same cycle → bit 4 ends at 1.
- Branch priority: lwStall active and PCSrcE=1 → StallF=StallD=0, FlushD=FlushE=1, FlushCnt +1, LoadStallCnt unchanged.
- Reset and saturation: assert rst_n=0 mid-op with PendingMask=0x0000_0600 → immediately 0. With CNT_W=4, force 20 flush cycles → FlushCnt=15. PerfClr → 0.
